// File: rtl/hex_line_sequencer.sv
// ---------------------------------------------------------------------------
// hex_line_sequencer
//
// Bus master and byte sequencer that turns a 4*L-bit value into a printable
// text line. On an accepted start it writes the value into the character
// memory as L lowercase ASCII hex digits (one bus write of the whole word),
// then reads memory addresses 0..11 in order and hands each returned byte
// to a serial transmitter. The memory supplies the "0x" prefix and the
// "\n\r" suffix around the digits, so the transmitted line is
// "0x" + digits + "\n\r".
//
// Ports
//   i_clk, i_reset_n      clock (rising edge) and asynchronous active-low reset
//   i_start, i_value      line request (sampled in IDLE only) and value to print
//   o_busy                high while a line is in progress
//   o_done                one-cycle pulse after the final byte is taken
//   o_err                 one-cycle pulse when a bus transaction times out
//   o_cyc/o_stb/o_we      bus cycle, strobe and write enable
//   o_addr, o_data        bus address and write data
//   i_stall, i_ack,
//   i_data                bus stall, acknowledge and read data (valid with ack)
//   o_tx_stb, o_tx_data   transmit byte valid and byte
//   i_tx_busy             transmitter busy; a byte moves on stb && !busy
//
// Every output is a register. Outputs are decoded from the next state, so
// they change on the same edge as the state and show the state they belong
// to for the whole cycle.
// ---------------------------------------------------------------------------
module hex_line_sequencer #(
    parameter int L       = 8,
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_start,
    input  logic [4*L-1:0] i_value,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic           o_cyc,
    output logic           o_stb,
    output logic           o_we,
    output logic [4:0]     o_addr,
    output logic [L*W-1:0] o_data,
    input  logic           i_stall,
    input  logic           i_ack,
    input  logic [W-1:0]   i_data,
    output logic           o_tx_stb,
    output logic [W-1:0]   o_tx_data,
    input  logic           i_tx_busy
);

    // Timeout counter only ever needs to hold 0..TIMEOUT-1.
    localparam int            CW         = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TCNT_LIMIT = CW'(TIMEOUT - 1);

    // Twelve characters per line: "0x", eight digits, "\n\r".
    localparam logic [3:0]    LAST_INDEX = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WACK,
        S_GAP,
        S_READ,
        S_RACK,
        S_SEND,
        S_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t           state_reg,   state_next;
    logic [3:0]       index_reg,   index_next;
    logic [4*L-1:0]   value_reg,   value_next;
    logic [CW-1:0]    tcnt_reg,    tcnt_next;
    logic [W-1:0]     tx_data_reg, tx_data_next;

    // Registered outputs
    logic             cyc_reg,     cyc_next;
    logic             stb_reg,     stb_next;
    logic             we_reg,      we_next;
    logic             busy_reg,    busy_next;
    logic             done_reg,    done_next;
    logic             err_reg,     err_next;
    logic             tx_stb_reg,  tx_stb_next;
    logic [4:0]       addr_reg,    addr_next;
    logic [L*W-1:0]   data_reg,    data_next;

    // Only an acknowledge in one of the two waiting states belongs to us;
    // anything else on i_ack is noise from the memory side.
    logic             ack_ok;
    logic             timeout_hit;

    // -----------------------------------------------------------------------
    // Hex encoding of the value being latched
    //
    // Built from value_next so that the write word is already correct in
    // the first WRITE cycle, the same edge that latches i_value. Byte 0
    // carries the most significant nibble so the digits read left to right
    // in address order.
    // -----------------------------------------------------------------------
    logic [L*W-1:0]   hex_word;

    for (genvar gi = 0; gi < L; gi++) begin : g_hex
        logic [3:0] nib;

        assign nib = value_next[4*(L-1-gi) +: 4];

        // 0-9 map onto '0'..'9'; 10-15 map onto 'a'..'f' ('a' - 10 = 8'h57).
        assign hex_word[W*gi +: W] = (nib < 4'd10) ? (W'(nib) + W'(8'h30))
                                                   : (W'(nib) + W'(8'h57));
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        value_next   = value_reg;
        tcnt_next    = tcnt_reg;
        tx_data_next = tx_data_reg;
        err_next     = 1'b0;

        ack_ok      = i_ack && ((state_reg == S_WACK) || (state_reg == S_RACK));

        // An ack landing on the limit cycle still completes the transaction.
        timeout_hit = cyc_reg && !ack_ok && (tcnt_reg == TCNT_LIMIT);

        // The counter measures how long the bus has been held open without
        // an answer; it is cleared on every entry into WRITE or READ below.
        if (cyc_reg && !ack_ok) begin
            tcnt_next = tcnt_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    value_next = i_value;
                    index_next = 4'd0;
                    tcnt_next  = '0;
                    state_next = S_WRITE;
                end
            end

            S_WRITE: begin
                if (!i_stall) begin
                    state_next = S_WACK;
                end
            end

            S_WACK: begin
                if (i_ack) begin
                    state_next = S_GAP;
                end
            end

            // Keeps cyc low for a cycle between the write and the first read.
            S_GAP: begin
                tcnt_next  = '0;
                state_next = S_READ;
            end

            S_READ: begin
                if (!i_stall) begin
                    state_next = S_RACK;
                end
            end

            S_RACK: begin
                if (i_ack) begin
                    tx_data_next = i_data;
                    state_next   = S_SEND;
                end
            end

            // The SEND cycle(s) also serve as the cyc-low gap before the
            // next read.
            S_SEND: begin
                if (!i_tx_busy) begin
                    if (index_reg == LAST_INDEX) begin
                        state_next = S_DONE;
                    end else begin
                        index_next = index_reg + 4'd1;
                        tcnt_next  = '0;
                        state_next = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort overrides whatever the state machine wanted to do.
        if (timeout_hit) begin
            state_next = S_IDLE;
            tcnt_next  = '0;
            err_next   = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state
    // -----------------------------------------------------------------------
    always_comb begin
        cyc_next    = 1'b0;
        stb_next    = 1'b0;
        we_next     = 1'b0;
        busy_next   = 1'b1;
        done_next   = 1'b0;
        tx_stb_next = 1'b0;
        addr_next   = 5'd0;
        data_next   = '0;

        case (state_next)
            S_IDLE: begin
                busy_next = 1'b0;
            end

            S_WRITE: begin
                cyc_next  = 1'b1;
                stb_next  = 1'b1;
                we_next   = 1'b1;
                data_next = hex_word;
            end

            // Write enable stays up until the ack closes the write cycle.
            S_WACK: begin
                cyc_next = 1'b1;
                we_next  = 1'b1;
            end

            S_GAP: begin
                busy_next = 1'b1;
            end

            S_READ: begin
                cyc_next  = 1'b1;
                stb_next  = 1'b1;
                addr_next = {1'b0, index_next};
            end

            S_RACK: begin
                cyc_next = 1'b1;
            end

            S_SEND: begin
                tx_stb_next = 1'b1;
            end

            S_DONE: begin
                busy_next = 1'b0;
                done_next = 1'b1;
            end

            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers. Reset takes effect immediately so a line in flight drops
    // the bus and the transmit strobe without waiting for a clock edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= S_IDLE;
            index_reg   <= 4'd0;
            value_reg   <= '0;
            tcnt_reg    <= '0;
            tx_data_reg <= '0;
            cyc_reg     <= 1'b0;
            stb_reg     <= 1'b0;
            we_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            tx_stb_reg  <= 1'b0;
            addr_reg    <= 5'd0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            value_reg   <= value_next;
            tcnt_reg    <= tcnt_next;
            tx_data_reg <= tx_data_next;
            cyc_reg     <= cyc_next;
            stb_reg     <= stb_next;
            we_reg      <= we_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            tx_stb_reg  <= tx_stb_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
        end
    end

    assign o_busy    = busy_reg;
    assign o_done    = done_reg;
    assign o_err     = err_reg;
    assign o_cyc     = cyc_reg;
    assign o_stb     = stb_reg;
    assign o_we      = we_reg;
    assign o_addr    = addr_reg;
    assign o_data    = data_reg;
    assign o_tx_stb  = tx_stb_reg;
    assign o_tx_data = tx_data_reg;

endmodule
